pipe_stage_reg: RTL

Parametrised inter-stage pipeline register that replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It moves an opaque payload bundle using a valid/ready handshake, supports exception flush, and optionally includes a 2-entry skid buffer. The skid buffer makes upstream ready a registered signal, breaking long stall paths (e.g. the data-cache stall into EX). It sits between any two adjacent pipeline stages; the stage wrapper packs and unpacks the payload fields.

---
 rtl/pipe_pkg.sv | 7 +
 rtl/pipe_slot.sv | 26 ++
 rtl/pipe_stage_reg.sv | 84 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: occupancy states and handshake helper shared by the pipeline register blocks
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;
  function automatic logic fire(input logic valid, input logic ready);
    return valid && ready;
  endfunction
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: W-bit payload register with valid bit; clear beats load, zero wipes payload on clear
module pipe_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic         zero,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      if (zero) q <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q <= d;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush and optional 2-entry skid buffer
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int W = 32,
  parameter bit SKID = 1,
  parameter bit CLEAR_ON_FLUSH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);
  logic in_f, out_f, zero;
  assign in_f = fire(in_valid, in_ready);
  assign out_f = fire(out_valid, out_ready);
  assign zero = flush && CLEAR_ON_FLUSH;
  if (SKID) begin : g_skid
    occ_e st, nxt;
    logic rdy, main_ld, main_clr, skid_ld, skid_clr, from_skid, skid_v;
    logic [W-1:0] skid_q;
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        st <= EMPTY;
        rdy <= 1'b1;
      end else begin
        st <= nxt;
        rdy <= nxt != TWO;
      end
    end
    always_comb begin
      nxt = st;
      main_ld = 1'b0;
      main_clr = flush;
      skid_ld = 1'b0;
      skid_clr = flush;
      from_skid = 1'b0;
      case (st)
        EMPTY: if (in_f) begin
          main_ld = 1'b1;
          nxt = ONE;
        end
        ONE: if (in_f && out_f) main_ld = 1'b1;
          else if (in_f) begin
            skid_ld = 1'b1;
            nxt = TWO;
          end else if (out_f) begin
            main_clr = 1'b1;
            nxt = EMPTY;
          end
        default: if (out_f) begin
          main_ld = 1'b1;
          from_skid = 1'b1;
          skid_clr = 1'b1;
          nxt = ONE;
        end
      endcase
    end
    pipe_slot #(.W(W)) u_main (
      .clk(clk), .rst(rst), .load(main_ld), .clear(main_clr), .zero(zero),
      .d(from_skid ? skid_q : in_data), .q(out_data), .valid(out_valid)
    );
    pipe_slot #(.W(W)) u_skid (
      .clk(clk), .rst(rst), .load(skid_ld), .clear(skid_clr), .zero(zero),
      .d(in_data), .q(skid_q), .valid(skid_v)
    );
    // ready comes straight off a flop so out_ready never reaches upstream combinationally
    assign in_ready = rdy;
    assign occupancy = {1'b0, out_valid} + {1'b0, skid_v};
  end else begin : g_single
    pipe_slot #(.W(W)) u_main (
      .clk(clk), .rst(rst), .load(in_f), .clear(flush || (out_f && !in_f)), .zero(zero),
      .d(in_data), .q(out_data), .valid(out_valid)
    );
    assign in_ready = !out_valid || out_ready;
    assign occupancy = {1'b0, out_valid};
  end
endmodule
